alu_op_issuer: RTL and testbench

//  Transmitter side of the ALU operand interface: accepts one operation per valid/ready request, drives
//  ce/opa/opb/mode/cmd/cin/inp_valid into the ALU, optionally splitting operands into two staggered beats,

---
 rtl/alu_op_issuer.sv | 176 +++++++++++++++++
 tb/tb_alu_op_issuer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// Drives one operation per request into the ALU (optionally as two staggered operand beats), then returns the result.
// Latency: first beat 1 cycle after accept, response L+1 cycles after the last beat; only IDLE accepts; RESP holds until rsp_ready.
module alu_op_issuer #(
    parameter int DATA_WIDTH = 8,
    parameter int CMD_WIDTH  = 4,
    parameter int MAX_SKEW   = 16,
    parameter int OP_LAT     = 1,
    parameter int MUL_LAT    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DATA_WIDTH-1:0]   req_opa,
    input  logic [DATA_WIDTH-1:0]   req_opb,
    input  logic [CMD_WIDTH-1:0]    req_cmd,
    input  logic                    req_mode,
    input  logic                    req_cin,
    input  logic [1:0]              req_order,
    input  logic [4:0]              req_gap,
    output logic                    alu_ce,
    output logic [DATA_WIDTH-1:0]   alu_opa,
    output logic [DATA_WIDTH-1:0]   alu_opb,
    output logic                    alu_mode,
    output logic [CMD_WIDTH-1:0]    alu_cmd,
    output logic                    alu_cin,
    output logic [1:0]              alu_inp_valid,
    input  logic [2*DATA_WIDTH-1:0] alu_res,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2*DATA_WIDTH-1:0] rsp_res,
    output logic                    rsp_clamped
);

    typedef enum logic [2:0] {
        S_IDLE, S_BEAT1, S_GAP, S_BEAT2, S_WAIT, S_RESP
    } state_t;

    localparam logic [4:0] GAP_MAX = 5'(MAX_SKEW - 1);
    localparam logic [4:0] LAT_OP  = 5'(OP_LAT);
    localparam logic [4:0] LAT_MUL = 5'(MUL_LAT);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   opa_q, opa_d;
    logic [DATA_WIDTH-1:0]   opb_q, opb_d;
    logic [CMD_WIDTH-1:0]    cmd_q, cmd_d;
    logic                    mode_q, mode_d;
    logic                    cin_q, cin_d;
    logic [1:0]              order_q, order_d;
    logic [4:0]              gap_q, gap_d;
    logic                    clamped_q, clamped_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [2*DATA_WIDTH-1:0] res_q, res_d;

    logic       split;
    logic       is_mul;
    logic [4:0] lat_m1;

    assign split  = (order_q == 2'b01) || (order_q == 2'b10);
    assign is_mul = mode_q && ((cmd_q == CMD_WIDTH'(9)) || (cmd_q == CMD_WIDTH'(10)));
    assign lat_m1 = (is_mul ? LAT_MUL : LAT_OP) - 5'd1;

    always_comb begin
        state_d       = state_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        cmd_d         = cmd_q;
        mode_d        = mode_q;
        cin_d         = cin_q;
        order_d       = order_q;
        gap_d         = gap_q;
        clamped_d     = clamped_q;
        cnt_d         = cnt_q;
        res_d         = res_q;
        alu_ce        = 1'b0;
        alu_inp_valid = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    opa_d     = req_opa;
                    opb_d     = req_opb;
                    cmd_d     = req_cmd;
                    mode_d    = req_mode;
                    cin_d     = req_cin;
                    order_d   = req_order;
                    clamped_d = req_gap > GAP_MAX;
                    gap_d     = (req_gap > GAP_MAX) ? GAP_MAX : req_gap;
                    state_d   = S_BEAT1;
                end
            end
            S_BEAT1: begin
                alu_ce        = 1'b1;
                alu_inp_valid = !split ? 2'b11 : (order_q == 2'b01 ? 2'b01 : 2'b10);
                if (!split) begin
                    cnt_d   = lat_m1;
                    state_d = S_WAIT;
                end else if (gap_q == 5'd0) begin
                    state_d = S_BEAT2;
                end else begin
                    cnt_d   = gap_q - 5'd1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                alu_ce = 1'b1;
                if (cnt_q == 5'd0) begin
                    state_d = S_BEAT2;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_BEAT2: begin
                alu_ce        = 1'b1;
                alu_inp_valid = (order_q == 2'b01) ? 2'b10 : 2'b01;
                cnt_d         = lat_m1;
                state_d       = S_WAIT;
            end
            S_WAIT: begin
                alu_ce = 1'b1;
                // Last WAIT cycle is cycle B+L: capture the result at its closing edge.
                if (cnt_q == 5'd0) begin
                    res_d   = alu_res;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            cmd_q     <= '0;
            mode_q    <= 1'b0;
            cin_q     <= 1'b0;
            order_q   <= 2'b00;
            gap_q     <= 5'd0;
            clamped_q <= 1'b0;
            cnt_q     <= 5'd0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            cmd_q     <= cmd_d;
            mode_q    <= mode_d;
            cin_q     <= cin_d;
            order_q   <= order_d;
            gap_q     <= gap_d;
            clamped_q <= clamped_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
        end
    end

    // Gated by rst so nothing is accepted (or advertised) while reset is held.
    assign req_ready   = (state_q == S_IDLE) && !rst;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_res     = res_q;
    assign rsp_clamped = clamped_q;
    assign alu_opa     = opa_q;
    assign alu_opb     = opb_q;
    assign alu_cmd     = cmd_q;
    assign alu_mode    = mode_q;
    assign alu_cin     = cin_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with a small behavioural ALU behind it.
module tb_alu_op_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_opa, req_opb;
    logic [3:0]  req_cmd;
    logic        req_mode, req_cin;
    logic [1:0]  req_order;
    logic [4:0]  req_gap;
    logic        alu_ce;
    logic [7:0]  alu_opa, alu_opb;
    logic        alu_mode;
    logic [3:0]  alu_cmd;
    logic        alu_cin;
    logic [1:0]  alu_inp_valid;
    logic [15:0] alu_res;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_res;
    logic        rsp_clamped;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_op_issuer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd),
        .req_mode(req_mode), .req_cin(req_cin), .req_order(req_order), .req_gap(req_gap),
        .alu_ce(alu_ce), .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_mode(alu_mode),
        .alu_cmd(alu_cmd), .alu_cin(alu_cin), .alu_inp_valid(alu_inp_valid),
        .alu_res(alu_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_clamped(rsp_clamped)
    );

    // Behavioural ALU: operand registers load on their inp_valid bit while ce=1.
    logic [7:0] a_reg, b_reg;
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= 8'h00;
            b_reg <= 8'h00;
        end else if (alu_ce) begin
            if (alu_inp_valid[0]) a_reg <= alu_opa;
            if (alu_inp_valid[1]) b_reg <= alu_opb;
        end
    end

    always_comb begin
        alu_res = {8'h00, a_reg ^ b_reg};
        if (alu_mode) begin
            case (alu_cmd)
                4'd0:    alu_res = {8'h00, a_reg} + {8'h00, b_reg} + {15'd0, alu_cin};
                4'd9:    alu_res = ({8'h00, a_reg} + 16'd1) * ({8'h00, b_reg} + 16'd1);
                4'd10:   alu_res = ({8'h00, a_reg} << 1) * {8'h00, b_reg};
                default: alu_res = 16'h0000;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] iv_log [0:63];
    logic       ce_log [0:63];
    int         rsp_cyc;

    // Leaves the bench in cycle T+1, where T is the accept cycle.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] cmd,
                         input logic m, input logic ci, input logic [1:0] ord, input logic [4:0] gap);
        int w;
        w = 0;
        while (!req_ready && w < 50) begin
            next_cyc();
            w++;
        end
        check("ready_before_req", req_ready, 1);
        req_opa = a; req_opb = b; req_cmd = cmd; req_mode = m; req_cin = ci;
        req_order = ord; req_gap = gap; req_valid = 1'b1;
        next_cyc();
        req_valid = 1'b0;
    endtask

    // Logs inp_valid/ce per cycle and stops in the first cycle showing rsp_valid.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] cmd,
                           input logic m, input logic ci, input logic [1:0] ord, input logic [4:0] gap);
        issue(a, b, cmd, m, ci, ord, gap);
        rsp_cyc = -1;
        for (int c = 1; c < 60 && rsp_cyc < 0; c++) begin
            iv_log[c] = alu_inp_valid;
            ce_log[c] = alu_ce;
            if (rsp_valid) rsp_cyc = c;
            else next_cyc();
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        req_opa = '0; req_opb = '0; req_cmd = '0; req_mode = 1'b0; req_cin = 1'b0;
        req_order = 2'b00; req_gap = '0;
        repeat (3) next_cyc();
        check("rst_req_ready", req_ready, 0);
        check("rst_alu_ce", alu_ce, 0);
        check("rst_inp_valid", alu_inp_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_res", rsp_res, 0);
        check("rst_alu_opa", alu_opa, 0);
        rst = 1'b0;
        next_cyc();
        check("post_rst_ready", req_ready, 1);

        // ADD both beats together
        run_txn(8'h12, 8'h34, 4'd0, 1'b1, 1'b0, 2'b11, 5'd0);
        check("add_iv_b1", iv_log[1], 2'b11);
        check("add_ce_b1", ce_log[1], 1);
        check("add_iv_wait", iv_log[2], 2'b00);
        check("add_ce_wait", ce_log[2], 1);
        check("add_rsp_cyc", rsp_cyc, 3);
        check("add_res", rsp_res, 16'h0046);
        check("add_clamped", rsp_clamped, 0);
        check("add_ce_resp", alu_ce, 0);
        next_cyc();
        check("add_rsp_drop", rsp_valid, 0);
        check("add_ready_back", req_ready, 1);

        // A then B, gap 5
        run_txn(8'h0F, 8'h01, 4'd0, 1'b1, 1'b0, 2'b01, 5'd5);
        check("o01_iv_b1", iv_log[1], 2'b01);
        for (int c = 2; c <= 6; c++) check("o01_iv_gap", iv_log[c], 2'b00);
        check("o01_ce_gap", ce_log[4], 1);
        check("o01_iv_b2", iv_log[7], 2'b10);
        check("o01_rsp_cyc", rsp_cyc, 9);
        check("o01_res", rsp_res, 16'h0010);
        next_cyc();

        // B then A, gap 20 clamped to 15
        run_txn(8'h20, 8'h05, 4'd0, 1'b1, 1'b0, 2'b10, 5'd20);
        check("clamp_iv_b1", iv_log[1], 2'b10);
        check("clamp_iv_gap_end", iv_log[16], 2'b00);
        check("clamp_iv_b2", iv_log[17], 2'b01);
        check("clamp_rsp_cyc", rsp_cyc, 19);
        check("clamp_flag", rsp_clamped, 1);
        check("clamp_res", rsp_res, 16'h0025);
        next_cyc();

        // gap exactly 15: not clamped
        run_txn(8'h01, 8'h01, 4'd0, 1'b1, 1'b1, 2'b01, 5'd15);
        check("g15_iv_b2", iv_log[17], 2'b10);
        check("g15_rsp_cyc", rsp_cyc, 19);
        check("g15_flag", rsp_clamped, 0);
        check("g15_res_cin", rsp_res, 16'h0003);
        next_cyc();

        // gap 0 skips GAP
        run_txn(8'h07, 8'h08, 4'd0, 1'b1, 1'b0, 2'b01, 5'd0);
        check("g0_iv_b2", iv_log[2], 2'b10);
        check("g0_rsp_cyc", rsp_cyc, 4);
        check("g0_res", rsp_res, 16'h000F);
        next_cyc();

        // multiply latencies
        run_txn(8'h03, 8'h04, 4'd9, 1'b1, 1'b0, 2'b11, 5'd0);
        check("mul9_rsp_cyc", rsp_cyc, 4);
        check("mul9_res", rsp_res, 16'h0014);
        next_cyc();
        run_txn(8'h03, 8'h04, 4'd10, 1'b1, 1'b0, 2'b00, 5'd0);
        check("mul10_iv_b1", iv_log[1], 2'b11);
        check("mul10_rsp_cyc", rsp_cyc, 4);
        check("mul10_res", rsp_res, 16'h0018);
        next_cyc();
        run_txn(8'h03, 8'h04, 4'd9, 1'b0, 1'b0, 2'b11, 5'd0);
        check("logic9_rsp_cyc", rsp_cyc, 3);
        check("logic9_res", rsp_res, 16'h0007);
        next_cyc();

        // response backpressure for 10 cycles
        rsp_ready = 1'b0;
        run_txn(8'h01, 8'h02, 4'd0, 1'b1, 1'b0, 2'b11, 5'd0);
        check("bp_rsp_cyc", rsp_cyc, 3);
        for (int k = 0; k < 10; k++) begin
            next_cyc();
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_res", rsp_res, 16'h0003);
            check("bp_alu_ce", alu_ce, 0);
            check("bp_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        next_cyc();
        check("bp_rsp_drop", rsp_valid, 0);
        check("bp_ready_back", req_ready, 1);

        // reset while in GAP
        issue(8'hAA, 8'h55, 4'd0, 1'b1, 1'b0, 2'b01, 5'd8);
        next_cyc();
        next_cyc();
        check("rgap_ce_in_gap", alu_ce, 1);
        rst = 1'b1;
        next_cyc();
        check("rgap_ce", alu_ce, 0);
        check("rgap_iv", alu_inp_valid, 2'b00);
        check("rgap_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        next_cyc();
        check("rgap_ready", req_ready, 1);
        for (int k = 0; k < 12; k++) begin
            check("rgap_no_rsp", rsp_valid, 0);
            next_cyc();
        end
        run_txn(8'h12, 8'h34, 4'd0, 1'b1, 1'b0, 2'b11, 5'd0);
        check("rgap_fresh_cyc", rsp_cyc, 3);
        check("rgap_fresh_res", rsp_res, 16'h0046);
        next_cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
